// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the multicycle CPU fetch path
package cpu_pkg;

  // next-PC select values driven by the control unit; 2'd3 behaves as PC_SEQ
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // fetch controller states
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection (seq / beq / j)
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_off;

  assign pc4        = pc + 32'd4;
  // word offset sign-extended and scaled to a byte offset
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  // pick the successor PC; reserved encodings fall back to sequential
  always_comb begin
    next_pc = pc4;
    case (pc_src)
      PC_BRANCH: next_pc = branch_taken ? (pc4 + branch_off) : pc4;
      PC_JUMP:   next_pc = {pc4[31:28], jtarget, 2'b00};
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - program counter owner and instruction fetch sequencer
module fetch_pc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          MEM_WORDS = 65
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic        if_strobe,
  output logic        ins_valid,
  input  logic        halt,
  input  logic        pc_wr_en,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  output logic        fault,
  output logic [31:0] retired
);

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         next_in_range;

  next_pc_calc u_next_pc (
    .pc           (pc),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .next_pc      (next_pc)
  );

  assign next_in_range = (next_pc[31:2] < MEM_LIMIT);

  // fetch sequencer: strobe the PC, wait for retire, then refetch or trap
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= {RESET_PC[31:2], 2'b00};
      if_strobe <= 1'b0;
      ins_valid <= 1'b0;
      fault     <= 1'b0;
      retired   <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (halt) begin
            if_strobe <= 1'b0;
          end else begin
            if_strobe <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if_strobe <= 1'b0;
          if (if_strobe) begin
            // memory returns the word one cycle after the strobe
            ins_valid <= 1'b1;
          end else if (ins_valid && pc_wr_en) begin
            pc        <= next_pc;
            retired   <= retired + 32'd1;
            ins_valid <= 1'b0;
            if (next_in_range) begin
              state <= S_FETCH;
            end else begin
              state <= S_FAULT;
              fault <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          if_strobe <= 1'b0;
          ins_valid <= 1'b0;
          fault     <= 1'b1;
        end
        default: begin
          state     <= S_FETCH;
          if_strobe <= 1'b0;
          ins_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        pc_wr_en = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] jtarget = 26'd0;

  logic [31:0] pc, retired;
  logic        if_strobe, ins_valid, fault;
  logic [31:0] w_pc, w_retired;
  logic        w_strobe, w_valid, w_fault;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_retired = 32'd0;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(65)) dut (
    .clk(clk), .reset(reset), .pc(pc), .if_strobe(if_strobe), .ins_valid(ins_valid),
    .halt(halt), .pc_wr_en(pc_wr_en), .pc_src(pc_src), .branch_taken(branch_taken),
    .imm16(imm16), .jtarget(jtarget), .fault(fault), .retired(retired)
  );

  // second instance starting at the top of the address space for the wrap case
  fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MEM_WORDS(65)) dut_w (
    .clk(clk), .reset(reset), .pc(w_pc), .if_strobe(w_strobe), .ins_valid(w_valid),
    .halt(halt), .pc_wr_en(pc_wr_en), .pc_src(pc_src), .branch_taken(branch_taken),
    .imm16(imm16), .jtarget(jtarget), .fault(w_fault), .retired(w_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic bt, input logic [15:0] imm,
                                             input logic [25:0] jt);
    logic [31:0] seq;
    int signed   off;
    seq = cur + 32'd4;
    off = 32'($signed(imm));
    if (src == 2'd1 && bt) return seq + 32'(off * 4);
    if (src == 2'd2) return (seq & 32'hF000_0000) | ({6'd0, jt} << 2);
    return seq;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pc_wr_en = 1'b0;
    halt = 1'b0;
    step();
    reset = 1'b0;
    exp_pc = 32'd0;
    exp_retired = 32'd0;
  endtask

  task automatic do_retire(input logic [1:0] src, input logic bt, input logic [15:0] imm,
                           input logic [25:0] jt, output bit tmo);
    int guard;
    guard = 0;
    tmo = 1'b0;
    while (!ins_valid && guard < 10) begin
      step();
      guard++;
    end
    if (!ins_valid) begin
      tmo = 1'b1;
      return;
    end
    pc_src = src;
    branch_taken = bt;
    imm16 = imm;
    jtarget = jt;
    pc_wr_en = 1'b1;
    step();
    pc_wr_en = 1'b0;
    pc_src = 2'($urandom);
    branch_taken = 1'($urandom);
    imm16 = 16'($urandom);
    jtarget = 26'($urandom);
    exp_pc = model_next(exp_pc, src, bt, imm, jt);
    exp_retired = exp_retired + 32'd1;
  endtask

  task automatic wait_fetch(output int strobes, output int waits, output bit tmo);
    strobes = 0;
    waits = 0;
    tmo = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      waits++;
      if (if_strobe) strobes++;
      if (ins_valid) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic es, ev;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      es = (c == 1);
      ev = (c >= 2);
      n_checks++;
      if (pc !== 32'd0 || if_strobe !== es || ins_valid !== ev || retired !== 32'd0 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_c%0d: pc=%h strobe=%b valid=%b retired=%0d fault=%b, required pc=0 strobe=%b valid=%b retired=0 fault=0",
                 c, pc, if_strobe, ins_valid, retired, fault, es, ev);
      end
      if (c < 5) step();
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    int s, w;
    for (int i = 0; i < 3; i++) begin
      do_retire(PC_SEQ, 1'b0, 16'd0, 26'd0, tmo);
      n_checks++;
      if (tmo || pc !== 32'(4 * (i + 1)) || retired !== exp_retired || ins_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_%0d: tmo=%b pc=%h retired=%0d valid=%b, required pc=%h retired=%0d valid=0",
                 i, tmo, pc, retired, ins_valid, 32'(4 * (i + 1)), exp_retired);
      end
      wait_fetch(s, w, tmo);
      n_checks++;
      if (tmo || s != 1 || w != 2) begin
        n_fail++;
        $display("FAIL seq_fetch_%0d: tmo=%b strobes=%0d cycles_to_valid=%0d, required strobes=1 cycles=2", i, tmo, s, w);
      end
    end
    n_checks++;
    if (retired !== 32'd3) begin
      n_fail++;
      $display("FAIL seq_retired: retired=%0d, required 3", retired);
    end
  endtask

  task automatic test_branch();
    logic [15:0] imms [3];
    logic        bts  [3];
    logic [31:0] want [3];
    bit tmo;
    int s, w;
    imms = '{16'h0001, 16'h0001, 16'hFFF9};
    bts  = '{1'b1, 1'b0, 1'b1};
    want = '{32'd36, 32'd32, 32'd4};
    for (int i = 0; i < 3; i++) begin
      do_retire(PC_JUMP, 1'b0, 16'd0, 26'd7, tmo);
      wait_fetch(s, w, tmo);
      n_checks++;
      if (tmo || pc !== 32'd28) begin
        n_fail++;
        $display("FAIL branch_setup_%0d: tmo=%b pc=%h, required 0000001c", i, tmo, pc);
      end
      do_retire(PC_BRANCH, bts[i], imms[i], 26'd0, tmo);
      n_checks++;
      if (tmo || pc !== want[i] || pc !== exp_pc || retired !== exp_retired || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL branch_%0d: tmo=%b pc=%h retired=%0d fault=%b, required pc=%h retired=%0d fault=0",
                 i, tmo, pc, retired, fault, want[i], exp_retired);
      end
      wait_fetch(s, w, tmo);
    end
  endtask

  task automatic test_jump_fault();
    bit tmo;
    int s, w;
    logic [31:0] r_before;
    do_retire(PC_JUMP, 1'b0, 16'd0, 26'd9, tmo);
    wait_fetch(s, w, tmo);
    do_retire(PC_JUMP, 1'b0, 16'd0, 26'h3F, tmo);
    wait_fetch(s, w, tmo);
    n_checks++;
    if (tmo || pc !== 32'h0000_00FC || fault !== 1'b0 || s != 1) begin
      n_fail++;
      $display("FAIL jump_fc: tmo=%b pc=%h fault=%b strobes=%0d, required pc=000000fc fault=0 strobes=1", tmo, pc, fault, s);
    end
    r_before = retired;
    do_retire(PC_JUMP, 1'b0, 16'd0, 26'h41, tmo);
    n_checks++;
    if (tmo || pc !== 32'h0000_0104 || fault !== 1'b1 || retired !== r_before + 32'd1 || ins_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_fault: tmo=%b pc=%h fault=%b retired=%0d valid=%b, required pc=00000104 fault=1 retired=%0d valid=0",
               tmo, pc, fault, retired, ins_valid, r_before + 32'd1);
    end
    s = 0;
    w = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (if_strobe || ins_valid) s++;
      if (pc !== 32'h0000_0104 || fault !== 1'b1 || retired !== r_before + 32'd1) w++;
    end
    n_checks++;
    if (s != 0 || w != 0) begin
      n_fail++;
      $display("FAIL fault_sticky: activity_cycles=%0d changed_cycles=%0d, required 0 and 0", s, w);
    end
  endtask

  task automatic test_reset_in_fault();
    apply_reset();
    n_checks++;
    if (pc !== 32'd0 || fault !== 1'b0 || retired !== 32'd0 || if_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fault: pc=%h fault=%b retired=%0d strobe=%b, required 0 0 0 0", pc, fault, retired, if_strobe);
    end
    step();
    n_checks++;
    if (if_strobe !== 1'b1 || pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_fault_refetch: strobe=%b pc=%h, required strobe=1 pc=0", if_strobe, pc);
    end
  endtask

  task automatic test_reset_hold_wr();
    bit tmo;
    int s, w;
    do_retire(PC_SEQ, 1'b0, 16'd0, 26'd0, tmo);
    wait_fetch(s, w, tmo);
    pc_src = PC_JUMP;
    jtarget = 26'd20;
    pc_wr_en = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pc_wr_en = 1'b0;
    exp_pc = 32'd0;
    exp_retired = 32'd0;
    n_checks++;
    if (tmo || pc !== 32'd0 || retired !== 32'd0 || fault !== 1'b0 || ins_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: tmo=%b pc=%h retired=%0d fault=%b valid=%b, required pc=0 retired=0 fault=0 valid=0",
               tmo, pc, retired, fault, ins_valid);
    end
    step();
    n_checks++;
    if (if_strobe !== 1'b1 || pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold_refetch: strobe=%b pc=%h, required strobe=1 pc=0", if_strobe, pc);
    end
  endtask

  task automatic test_halt();
    bit tmo;
    int bad;
    apply_reset();
    halt = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (if_strobe !== 1'b0 || pc !== 32'd0) bad++;
    end
    halt = 1'b0;
    step();
    n_checks++;
    if (bad != 0 || if_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_fetch: bad_cycles=%0d strobe_after=%b, required 0 and 1", bad, if_strobe);
    end
    step();
    halt = 1'b1;
    do_retire(PC_SEQ, 1'b0, 16'd0, 26'd0, tmo);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (if_strobe !== 1'b0 || pc !== 32'd4) bad++;
    end
    halt = 1'b0;
    step();
    n_checks++;
    if (tmo || bad != 0 || if_strobe !== 1'b1 || pc !== 32'd4) begin
      n_fail++;
      $display("FAIL halt_after_hold: tmo=%b bad_cycles=%0d strobe=%b pc=%h, required 0 bad, strobe=1 pc=00000004",
               tmo, bad, if_strobe, pc);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step();
    step();
    n_checks++;
    if (w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_start: pc=%h valid=%b, required pc=fffffffc valid=1", w_pc, w_valid);
    end
    pc_src = PC_SEQ;
    pc_wr_en = 1'b1;
    step();
    pc_wr_en = 1'b0;
    step();
    n_checks++;
    if (w_pc !== 32'd0 || w_fault !== 1'b0 || w_strobe !== 1'b1 || w_retired !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_seq: pc=%h fault=%b strobe=%b retired=%0d, required pc=0 fault=0 strobe=1 retired=1",
               w_pc, w_fault, w_strobe, w_retired);
    end
  endtask

  task automatic test_random();
    bit tmo;
    int s, w, hold, bad;
    logic [1:0]  src;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] jt;
    logic        exp_fault;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      hold = $urandom_range(0, 2);
      bad = 0;
      for (int k = 0; k < hold; k++) begin
        if (!ins_valid) break;
        pc_src = 2'($urandom);
        pc_wr_en = 1'b0;
        step();
        if (pc !== exp_pc || ins_valid !== 1'b1 || if_strobe !== 1'b0) bad++;
      end
      src = 2'($urandom_range(0, 3));
      bt  = 1'($urandom);
      imm = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 16)) - 8);
      jt  = 26'($urandom_range(0, 80));
      do_retire(src, bt, imm, jt, tmo);
      exp_fault = ((exp_pc >> 2) >= 32'd65);
      n_checks++;
      if (tmo || bad != 0 || pc !== exp_pc || retired !== exp_retired || fault !== exp_fault) begin
        n_fail++;
        $display("FAIL random_%0d: tmo=%b unstable=%0d pc=%h retired=%0d fault=%b, required pc=%h retired=%0d fault=%b",
                 n, tmo, bad, pc, retired, fault, exp_pc, exp_retired, exp_fault);
      end
      if (exp_fault) begin
        step();
        step();
        n_checks++;
        if (if_strobe !== 1'b0 || fault !== 1'b1 || pc !== exp_pc) begin
          n_fail++;
          $display("FAIL random_fault_%0d: strobe=%b fault=%b pc=%h, required strobe=0 fault=1 pc=%h",
                   n, if_strobe, fault, pc, exp_pc);
        end
        apply_reset();
      end else begin
        wait_fetch(s, w, tmo);
        n_checks++;
        if (tmo || s != 1 || pc !== exp_pc) begin
          n_fail++;
          $display("FAIL random_fetch_%0d: tmo=%b strobes=%0d pc=%h, required strobes=1 pc=%h", n, tmo, s, pc, exp_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_branch();
    test_jump_fault();
    test_reset_in_fault();
    test_reset_hold_wr();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
